// File: rtl/dmem_mmio_responder_pkg.sv
// dmem_mmio_responder_pkg: access-type codes, MMIO map, STAT layout and UART state type
package dmem_mmio_responder_pkg;
  localparam logic [2:0] DM_WORD = 3'b000;
  localparam logic [2:0] DM_HALF = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;
  localparam logic [23:0] MMIO_BASE = 24'hFFFF00;
  localparam logic [7:0] OFF_LED = 8'h00;
  localparam logic [7:0] OFF_SW = 8'h04;
  localparam logic [7:0] OFF_TCNT = 8'h08;
  localparam logic [7:0] OFF_TCMP = 8'h0C;
  localparam logic [7:0] OFF_UTX = 8'h10;
  localparam logic [7:0] OFF_STAT = 8'h14;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_MISALIGN = 3;
  localparam int ST_OVERFLOW = 4;
  localparam int ST_TMATCH = 5;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/dmem_mmio_responder_uart_tx_fifo.sv
// dmem_mmio_responder_uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter
module dmem_mmio_responder_uart_tx_fifo
  import dmem_mmio_responder_pkg::*;
#(
  parameter int CLK_DIV = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       drop,
  output logic       txd
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV + 1);
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic [CW-1:0] baud, baud_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shreg, shreg_n;
  uart_state_e state, state_n;
  logic pop, accept, tick;
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = (wr_ptr - rd_ptr) == (PW + 1)'(FIFO_DEPTH);
    tick = baud == CW'(CLK_DIV - 1);
    state_n = state;
    baud_n = tick ? '0 : baud + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n = shreg;
    pop = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          pop = 1'b1;
          shreg_n = mem[rd_ptr[PW-1:0]];
          state_n = START;
        end
      end
      START: if (tick) begin
        state_n = DATA;
        bit_idx_n = '0;
      end
      DATA: if (tick) begin
        shreg_n = shreg >> 1;
        bit_idx_n = bit_idx + 1'b1;
        state_n = bit_idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        pop = !empty;
        shreg_n = empty ? shreg : mem[rd_ptr[PW-1:0]];
        state_n = empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
    accept = push && (!full || pop);
    drop = push && full && !pop;
    busy = state != IDLE;
    txd = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      shreg <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_idx <= bit_idx_n;
      shreg <= shreg_n;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr[PW-1:0]] <= data;
endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data RAM plus LED/switch/timer/UART MMIO responder for the core's MEM stage
module dmem_mmio_responder
  import dmem_mmio_responder_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int CLK_DIV = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  input  logic [2:0]  DMType,
  output logic [31:0] Data_out,
  input  logic [15:0] sw_i,
  output logic [15:0] led_o,
  output logic        uart_txd,
  output logic        irq_timer
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] tcnt, tcmp, stat, mmio_rd, rd_word, shifted, wdata;
  logic [AW-1:0] idx;
  logic [7:0] woff;
  logic [3:0] be;
  logic is_ram, is_mmio, is_half, is_byte, misal, ram_we, mmio_we, bad_wr, stat_clr, tx_push;
  logic misalign, overflow, tmatch, fifo_full, fifo_empty, tx_busy, tx_drop;
  logic unused_addr;
  always_comb begin
    unused_addr = ^Addr_in[15:AW+2];
    is_ram = Addr_in[31:16] == '0;
    is_mmio = Addr_in[31:8] == MMIO_BASE;
    idx = Addr_in[AW+1:2];
    woff = {Addr_in[7:2], 2'b00};
    is_half = DMType == DM_HALF || DMType == DM_HALF_U;
    is_byte = DMType == DM_BYTE || DMType == DM_BYTE_U;
    misal = is_half ? Addr_in[0] : !is_byte && Addr_in[1:0] != 2'b00;
    stat = '0;
    stat[ST_FULL] = fifo_full;
    stat[ST_EMPTY] = fifo_empty;
    stat[ST_BUSY] = tx_busy;
    stat[ST_MISALIGN] = misalign;
    stat[ST_OVERFLOW] = overflow;
    stat[ST_TMATCH] = tmatch;
    mmio_rd = woff == OFF_LED ? {16'b0, led_o} :
              woff == OFF_SW ? {16'b0, sw_i} :
              woff == OFF_TCNT ? tcnt :
              woff == OFF_TCMP ? tcmp :
              woff == OFF_STAT ? stat : '0;
    rd_word = is_ram ? ram[idx] : is_mmio ? mmio_rd : '0;
    shifted = rd_word >> {Addr_in[1:0], 3'b000};
    Data_out = misal ? '0 :
               DMType == DM_HALF ? {{16{shifted[15]}}, shifted[15:0]} :
               DMType == DM_HALF_U ? {16'b0, shifted[15:0]} :
               DMType == DM_BYTE ? {{24{shifted[7]}}, shifted[7:0]} :
               DMType == DM_BYTE_U ? {24'b0, shifted[7:0]} : rd_word;
    wdata = is_half ? {2{Data_in[15:0]}} : is_byte ? {4{Data_in[7:0]}} : Data_in;
    be = is_half ? (Addr_in[1] ? 4'b1100 : 4'b0011) : is_byte ? 4'b0001 << Addr_in[1:0] : 4'b1111;
    ram_we = mem_w && is_ram && !misal;
    mmio_we = mem_w && is_mmio && !misal && !is_half && !is_byte;
    bad_wr = mem_w && (is_ram || is_mmio) && (misal || (is_mmio && (is_half || is_byte)));
    stat_clr = mmio_we && woff == OFF_STAT;
    tx_push = mmio_we && woff == OFF_UTX;
    irq_timer = tmatch;
  end
  always_ff @(posedge clk)
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk) begin
    if (reset) begin
      led_o <= '0;
      tcnt <= '0;
      tcmp <= '1;
      misalign <= 1'b0;
      overflow <= 1'b0;
      tmatch <= 1'b0;
    end else begin
      if (mmio_we && woff == OFF_LED) led_o <= Data_in[15:0];
      if (mmio_we && woff == OFF_TCMP) tcmp <= Data_in;
      tcnt <= mmio_we && woff == OFF_TCNT ? Data_in : tcnt + 32'd1;
      misalign <= bad_wr || (misalign && !(stat_clr && Data_in[ST_MISALIGN]));
      overflow <= tx_drop || (overflow && !(stat_clr && Data_in[ST_OVERFLOW]));
      tmatch <= tcnt == tcmp || (tmatch && !(stat_clr && Data_in[ST_TMATCH]));
    end
  end
  dmem_mmio_responder_uart_tx_fifo #(
    .CLK_DIV(CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_uart_tx_fifo (
    .clk(clk),
    .reset(reset),
    .push(tx_push),
    .data(Data_in[7:0]),
    .full(fifo_full),
    .empty(fifo_empty),
    .busy(tx_busy),
    .drop(tx_drop),
    .txd(uart_txd)
  );
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: randomized and directed checks of RAM, MMIO, timer and UART against a byte-level model
module tb_dmem_mmio_responder;
  localparam logic [31:0] A_LED = 32'hFFFF0000;
  localparam logic [31:0] A_SW = 32'hFFFF0004;
  localparam logic [31:0] A_TCNT = 32'hFFFF0008;
  localparam logic [31:0] A_TCMP = 32'hFFFF000C;
  localparam logic [31:0] A_UTX = 32'hFFFF0010;
  localparam logic [31:0] A_STAT = 32'hFFFF0014;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_w = 1'b0;
  logic [31:0] Addr_in = '0;
  logic [31:0] Data_in = '0;
  logic [2:0] DMType = '0;
  logic [31:0] Data_out;
  logic [15:0] sw_i = '0;
  logic [15:0] led_o;
  logic uart_txd, irq_timer;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] bm [1024];
  logic rec = 1'b0;
  logic q [$];
  always #5 clk = ~clk;
  always @(negedge clk) if (rec) q.push_back(uart_txd);
  dmem_mmio_responder #(.RAM_WORDS(256), .CLK_DIV(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .mem_w(mem_w), .Addr_in(Addr_in), .Data_in(Data_in),
    .DMType(DMType), .Data_out(Data_out), .sw_i(sw_i), .led_o(led_o),
    .uart_txd(uart_txd), .irq_timer(irq_timer)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    @(negedge clk);
    mem_w = 1'b1;
    Addr_in = a;
    Data_in = d;
    DMType = t;
  endtask
  task automatic idle();
    @(negedge clk);
    mem_w = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [2:0] t, output logic [31:0] d);
    @(negedge clk);
    mem_w = 1'b0;
    Addr_in = a;
    DMType = t;
    #1;
    d = Data_out;
  endtask
  function automatic int unsigned sz(input logic [2:0] t);
    return (t == 3'd1 || t == 3'd2) ? 2 : (t == 3'd3 || t == 3'd4) ? 1 : 4;
  endfunction
  function automatic void m_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    if (a % sz(t) != 0) return;
    for (int i = 0; i < int'(sz(t)); i++) bm[(a + i) % 1024] = d[8*i +: 8];
  endfunction
  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] t);
    logic [31:0] v;
    v = '0;
    if (a % sz(t) != 0) return '0;
    for (int i = 0; i < int'(sz(t)); i++) v = v | (32'(bm[(a + i) % 1024]) << (8 * i));
    if (t == 3'd1 && v[15]) v = v | 32'hFFFF0000;
    if (t == 3'd3 && v[7]) v = v | 32'hFFFFFF00;
    return v;
  endfunction
  initial begin
    logic [31:0] d, a, v, e;
    logic [2:0] t;
    logic [7:0] tx_b [10];
    logic [7:0] rx [$];
    logic [7:0] bt;
    int i, hi, j;
    repeat (2) @(negedge clk);
    chk("rst_led", 32'(led_o), 32'h0);
    chk("rst_txd", 32'(uart_txd), 32'h1);
    chk("rst_irq", 32'(irq_timer), 32'h0);
    rd(A_TCNT, 3'd0, d);
    chk("rst_tcnt", d, 32'h0);
    rd(A_TCMP, 3'd0, d);
    chk("rst_tcmp", d, 32'hFFFFFFFF);
    rd(A_STAT, 3'd0, d);
    chk("rst_stat", d, 32'h2);
    reset = 1'b0;
    for (int k = 0; k < 256; k++) begin
      v = $urandom;
      wr(32'(k * 4), v, 3'd0);
      m_store(32'(k * 4), v, 3'd0);
    end
    repeat (400) begin
      a = $urandom_range(0, 65535);
      t = 3'($urandom_range(0, 7));
      v = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        wr(a, v, t);
        m_store(a, v, t);
      end else begin
        rd(a, t, d);
        chk("rand_load", d, m_load(a, t));
      end
    end
    wr(A_STAT, 32'h38, 3'd0);
    wr(32'h10, 32'h8899AABB, 3'd0);
    m_store(32'h10, 32'h8899AABB, 3'd0);
    rd(32'h11, 3'd3, d);
    chk("lb_11", d, 32'hFFFFFFAA);
    rd(32'h11, 3'd4, d);
    chk("lbu_11", d, 32'h000000AA);
    rd(32'h12, 3'd1, d);
    chk("lh_12", d, 32'hFFFF8899);
    rd(32'h12, 3'd2, d);
    chk("lhu_12", d, 32'h00008899);
    rd(32'h12, 3'd0, d);
    chk("lw_misaligned", d, 32'h0);
    rd(32'h11, 3'd1, d);
    chk("lh_misaligned", d, 32'h0);
    wr(32'h13, 32'h0000005A, 3'd3);
    m_store(32'h13, 32'h0000005A, 3'd3);
    rd(32'h10, 3'd0, d);
    chk("lw_after_sb", d, 32'h5A99AABB);
    rd(A_STAT, 3'd0, d);
    chk("stat_misalign_clear0", 32'(d[3]), 32'h0);
    wr(32'h11, 32'h0000FFFF, 3'd1);
    rd(32'h10, 3'd0, d);
    chk("lw_after_bad_sh", d, 32'h5A99AABB);
    rd(A_STAT, 3'd0, d);
    chk("stat_misalign_set", 32'(d[3]), 32'h1);
    wr(A_STAT, 32'h8, 3'd0);
    rd(A_STAT, 3'd0, d);
    chk("stat_misalign_w1c", 32'(d[3]), 32'h0);
    wr(A_LED, 32'h1234ABCD, 3'd0);
    idle();
    chk("led_out", 32'(led_o), 32'hABCD);
    rd(A_LED, 3'd0, d);
    chk("led_read", d, 32'h0000ABCD);
    wr(A_LED, 32'h0, 3'd3);
    rd(A_LED, 3'd0, d);
    chk("led_subword_dropped", d, 32'h0000ABCD);
    rd(A_STAT, 3'd0, d);
    chk("mmio_subword_misalign", 32'(d[3]), 32'h1);
    wr(A_STAT, 32'h8, 3'd0);
    sw_i = 16'($urandom);
    rd(A_SW, 3'd0, d);
    chk("sw_read", d, {16'h0, sw_i});
    rd(A_SW + 32'd1, 3'd4, d);
    chk("sw_byte_hi", d, {24'h0, sw_i[15:8]});
    rd(32'hFFFF0018, 3'd0, d);
    chk("unmapped_mmio", d, 32'h0);
    wr(32'h00010004, 32'hDEADBEEF, 3'd0);
    rd(32'h00010004, 3'd0, d);
    chk("unmapped_high", d, 32'h0);
    rd(32'h4, 3'd0, d);
    chk("unmapped_no_alias", d, m_load(32'h4, 3'd0));
    wr(A_TCNT, 32'hFFFFFFFE, 3'd0);
    rd(A_TCNT, 3'd0, d);
    chk("tcnt_load", d, 32'hFFFFFFFE);
    rd(A_TCNT, 3'd0, d);
    chk("tcnt_inc", d, 32'hFFFFFFFF);
    rd(A_TCNT, 3'd0, d);
    chk("tcnt_wrap", d, 32'h0);
    rd(A_STAT, 3'd0, d);
    chk("tmatch_at_ffff", 32'(d[5]), 32'h1);
    wr(A_TCNT, 32'd100, 3'd0);
    wr(A_STAT, 32'h20, 3'd0);
    wr(A_TCMP, 32'd5, 3'd0);
    wr(A_TCNT, 32'd0, 3'd0);
    idle();
    chk("irq_after_clear", 32'(irq_timer), 32'h0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("irq_cycle_%0d", c), 32'(irq_timer), (c == 6) ? 32'h1 : 32'h0);
    end
    repeat (5) @(negedge clk);
    chk("irq_sticky", 32'(irq_timer), 32'h1);
    wr(A_STAT, 32'h20, 3'd0);
    idle();
    chk("irq_w1c", 32'(irq_timer), 32'h0);
    wr(A_UTX, 32'h41, 3'd0);
    for (int s = 0; s <= 41; s++) begin
      rd(A_STAT, 3'd0, d);
      j = (s - 1) / 4;
      e = (s == 0 || s == 41) ? 32'h1 : (j == 0) ? 32'h0 : (j <= 8) ? 32'((8'h41 >> (j - 1)) & 8'h1) : 32'h1;
      chk($sformatf("tx41_line_%0d", s), 32'(uart_txd), e);
      chk($sformatf("tx41_busy_%0d", s), 32'(d[2]), (s == 0 || s == 41) ? 32'h0 : 32'h1);
      if (s == 0) chk("tx41_queued", 32'(d[1]), 32'h0);
    end
    rec = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tx_b[k] = 8'($urandom);
      wr(A_UTX, {24'h0, tx_b[k]}, 3'd0);
    end
    rd(A_STAT, 3'd0, d);
    chk("burst_overflow", 32'(d[4]), 32'h1);
    chk("burst_full", 32'(d[0]), 32'h1);
    repeat (380) @(negedge clk);
    rec = 1'b0;
    i = 0;
    while (i + 40 <= q.size()) begin
      if (q[i] == 1'b0) begin
        for (int b = 0; b < 8; b++) bt[b] = q[i + 4 * (b + 1) + 2];
        chk("rx_stop_bit", 32'(q[i + 38]), 32'h1);
        rx.push_back(bt);
        i += 39;
      end else begin
        i++;
      end
    end
    chk("rx_frames", 32'(rx.size()), 32'd9);
    for (int k = 0; k < 9; k++)
      chk($sformatf("rx_byte_%0d", k), (k < rx.size()) ? 32'(rx[k]) : 32'hDEAD, 32'(tx_b[k]));
    rd(A_STAT, 3'd0, d);
    chk("burst_drained", 32'(d[2:0]), 32'h2);
    wr(A_STAT, 32'h10, 3'd0);
    rd(A_STAT, 3'd0, d);
    chk("overflow_w1c", 32'(d[4]), 32'h0);
    wr(A_LED, 32'hFFFF, 3'd0);
    wr(A_UTX, 32'h00, 3'd0);
    wr(A_UTX, 32'h55, 3'd0);
    wr(A_UTX, 32'h66, 3'd0);
    idle();
    repeat (5) @(negedge clk);
    chk("mid_data_low", 32'(uart_txd), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_txd", 32'(uart_txd), 32'h1);
    chk("reset_led", 32'(led_o), 32'h0);
    rd(A_STAT, 3'd0, d);
    chk("reset_stat", d, 32'h2);
    rd(A_TCNT, 3'd0, d);
    chk("reset_tcnt", d, 32'h0);
    reset = 1'b0;
    hi = 0;
    repeat (60) begin
      @(negedge clk);
      hi += int'(uart_txd);
    end
    chk("reset_queue_cleared", 32'(hi), 32'd60);
    rd(32'h10, 3'd0, d);
    chk("ram_kept_over_reset", d, 32'h5A99AABB);
    rd(32'h20, 3'd0, d);
    chk("ram_kept_model", d, m_load(32'h20, 3'd0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder end of the CPU data-memory interface. It services the core's MEM-stage requests: address, store data, write strobe and DMType.
- Contains word-organised data RAM with sub-word load/store handling, plus a small MMIO window for the onboard application: LEDs, switches, a 32-bit timer and a UART transmitter with a TX FIFO.
- Sits beside the core in the onboard top level. Reads are combinational, so load data is valid in the same MEM cycle; writes commit on the clock edge.

Parameters:
- RAM_WORDS, 256, data RAM depth in 32-bit words. Must be a power of 2.
- CLK_DIV, 868, clocks per UART bit (100 MHz / 115200).
- FIFO_DEPTH, 8, UART TX FIFO entries. Must be a power of 2.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- mem_w  in  1  write strobe from the core's MEM stage
- Addr_in  in  32  byte address
- Data_in  in  32  store data, unshifted; byte/half data is in the low bits
- DMType  in  3  access type: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned
- Data_out  out  32  load data, extended per DMType
- sw_i  in  16  board switches
- led_o  out  16  LED register
- uart_txd  out  1  UART serial output, idle high
- irq_timer  out  1  timer match flag

Behaviour:
- Address map:
  - RAM: Addr_in[31:16] = 0. Word index = Addr_in[log2(RAM_WORDS)+1:2]; higher bits alias.
  - MMIO: Addr_in[31:8] = 0xFFFF00.
    - +0x00 LED (RW, low 16 bits)
    - +0x04 SW (RO, zero-extended)
    - +0x08 TCNT (RW)
    - +0x0C TCMP (RW)
    - +0x10 UTX (WO; write pushes Data_in[7:0])
    - +0x14 STAT (RW1C)
  - Any other address: reads 0, writes ignored, no error.
- Alignment: half accesses need Addr_in[0] = 0; word accesses need Addr_in[1:0] = 00.
  - Misaligned read returns 0.
  - Misaligned write is dropped and sets STAT.misalign.
- Loads:
  - Select byte/half lane by Addr_in[1:0].
  - Sign-extend for types 001/011; zero-extend for 010/100.
  - Undefined DMType values 101–111 behave as word.
- RAM stores update only the addressed lanes, via byte enables; other lanes are unchanged. RAM is not cleared by reset.
- MMIO writes require DMType = word. Sub-word MMIO writes are dropped and set STAT.misalign. MMIO reads use the normal lane extraction.
- STAT bits:
  - [0] fifo_full
  - [1] fifo_empty
  - [2] tx_busy
  - [3] misalign (sticky)
  - [4] overflow (sticky)
  - [5] tmatch (sticky)
  - Writing 1 clears a sticky bit. A set event in the same cycle as the clear wins.
- Timer:
  - TCNT increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
  - A CPU write loads Data_in and suppresses that cycle's increment.
  - tmatch sets in the cycle after TCNT == TCMP.
  - irq_timer = tmatch.
- UART TX FIFO:
  - A write to UTX pushes one byte.
  - If the FIFO is full and no pop occurs this cycle, the byte is dropped and overflow is set.
  - A push and a pop in the same cycle while full: the pop happens and the push is accepted.
- UART TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: when the FIFO is non-empty, pop the head into a shift register and go to START.
  - Each state lasts CLK_DIV cycles, counted by a baud counter.
  - Line levels: START drives 0; DATA drives 8 bits LSB first; STOP drives 1.
  - After STOP: if the FIFO is non-empty, pop and go straight to START; otherwise go to IDLE.
  - tx_busy = state != IDLE.
- Reset values: Data_out is combinational. The following clear within the reset cycle:
  - led_o = 0
  - TCNT = 0
  - TCMP = 0xFFFFFFFF
  - all sticky flags = 0, so irq_timer = 0
  - FIFO empty
  - FSM = IDLE
  - uart_txd = 1
- Reset mid-frame: uart_txd returns to 1 on the next edge and the frame is abandoned. Reset also clears queued bytes.

Decomposition:
- Shared package holds:
  - DMType codes, matching the core's control encoding
  - MMIO base address and register offsets
  - STAT bit indices
- Natural sub-module: uart_tx_fifo, containing the FIFO, FSM and baud counter, with push/data/full/empty/busy/txd ports.
- RAM, load/store lane logic, timer and register decode stay in the top block.

Test Plan:
- Store word 0x8899AABB at 0x10. Then:
  - load byte @0x11 -> 0xFFFFFFAA
  - load byte-unsigned @0x11 -> 0x000000AA
  - load half @0x12 -> 0xFFFF8899
- Store byte 0x5A @0x13, then word-load @0x10 -> 0x5A99AABB. Then store half @0x11 -> RAM unchanged and STAT[3] = 1; write 0x8 to STAT -> STAT[3] = 0.
- Write 0x00000005 to TCMP and 0 to TCNT -> irq_timer rises exactly 6 cycles after the TCNT write edge. Stays high until STAT is written with 0x20.
- Push 0x41 to UTX with CLK_DIV = 4 -> uart_txd, from the first START cycle: 0 for 4 clocks, bits 1,0,0,0,0,0,1,0 for 4 clocks each, then 1. tx_busy drops after the stop bit.
- Push 10 bytes back-to-back with FIFO_DEPTH = 8 -> first byte pops immediately, next 8 fill the FIFO, last byte is dropped and STAT[4] = 1. 9 frames are transmitted.
- Assert reset mid-DATA -> uart_txd = 1, FIFO empty, led_o = 0, TCNT = 0 after the edge. RAM word 0x10 still reads 0x5A99AABB.
